// File: rtl/ysyx_220053_dff_reg.sv
// ----------------------------------------------------------------------------
// ysyx_220053_dff_reg
//
// Generic WIDTH-bit state element with synchronous active-high reset and
// write enable. It is the register reused for the PC, the CSRs and the
// pipeline registers.
//
// Parameters
//   WIDTH      data width in bits, 1..1024
//   RESET_VAL  value loaded on reset. Only its low WIDTH bits are used.
//              A narrower value is zero-extended when it is assigned.
//
// Ports (positional order is fixed; instantiation sites connect by position)
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous reset, active high, has priority over wen
//   din   in   WIDTH  next-state data, loaded when wen=1
//   dout  out  WIDTH  current register contents, driven straight from the flop
//   wen   in   1      write enable, active high
// ----------------------------------------------------------------------------
module ysyx_220053_dff_reg #(
   parameter int             WIDTH     = 1,
   parameter logic [1023:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   input  logic             wen
);

   // Reject illegal widths at elaboration time.
   if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
      $error("ysyx_220053_dff_reg: WIDTH must be in 1..1024");
   end

   // Keep only the low WIDTH bits of the reset value.
   localparam logic [WIDTH-1:0] RESET_V = RESET_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] dout_q;

   // NOTE: state is updated with non-blocking assignments, so every reader
   // sees the value from before the edge and there is no race between flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= RESET_V;
      end else begin
         // A conditional operator instead of an if: an X on wen merges din
         // and the held value into X bits rather than silently holding.
         dout_q <= wen ? din : dout_q;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_ysyx_220053_dff_reg.sv
// ----------------------------------------------------------------------------
// tb_ysyx_220053_dff_reg
//
// Three instances:
//   u_a  WIDTH=64, RESET_VAL=80000000  (PC-style register)
//   u_b  WIDTH=1,  RESET_VAL=1
//   u_c  WIDTH=8,  RESET_VAL=1AB       (low byte AB is kept)
//
// The reference model holds the expected register contents. At every rising
// edge it applies the rule "reset wins, then a write loads din, otherwise the
// value is held". A compare process checks all three outputs on every
// falling edge. The directed sequence pins the model with literal values.
// ----------------------------------------------------------------------------
module tb_ysyx_220053_dff_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        wen_a, wen_b, wen_c;
   logic [63:0] din_a, dout_a;
   logic        din_b, dout_b;
   logic [7:0]  din_c, dout_c;

   ysyx_220053_dff_reg #(.WIDTH(64), .RESET_VAL(1024'h8000_0000)) u_a (
      .clk(clk), .rst(rst), .din(din_a), .dout(dout_a), .wen(wen_a));
   ysyx_220053_dff_reg #(.WIDTH(1), .RESET_VAL(1024'h1)) u_b (
      .clk(clk), .rst(rst), .din(din_b), .dout(dout_b), .wen(wen_b));
   ysyx_220053_dff_reg #(.WIDTH(8), .RESET_VAL(1024'h1AB)) u_c (
      .clk(clk), .rst(rst), .din(din_c), .dout(dout_c), .wen(wen_c));

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   logic [63:0] exp_a;
   logic        exp_b;
   logic [7:0]  exp_c;
   bit          model_valid = 1'b0;

   // Inputs change 1 time unit after each rising edge, so at the edge the
   // model reads the same values that the DUT samples.
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         exp_a       = 64'h8000_0000;
         exp_b       = 1'b1;
         exp_c       = 8'hAB;
         model_valid = 1'b1;
      end else begin
         if (wen_a) exp_a = din_a;
         if (wen_b) exp_b = din_b;
         if (wen_c) exp_c = din_c;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("cmp_a", dout_a, exp_a);
         check("cmp_b", {63'd0, dout_b}, {63'd0, exp_b});
         check("cmp_c", {56'd0, dout_c}, {56'd0, exp_c});
      end
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic prev_b;

      // Reset held for two edges while a write is also requested.
      rst   = 1'b1;
      wen_a = 1'b1; din_a = 64'h1234;
      wen_b = 1'b1; din_b = 1'b0;
      wen_c = 1'b1; din_c = 8'h55;
      edge1();
      check("rst_edge1_a", dout_a, 64'h8000_0000);
      check("rst_edge1_b", {63'd0, dout_b}, 64'd1);
      check("rst_edge1_c", {56'd0, dout_c}, 64'hAB);
      edge1();
      check("rst_edge2_a", dout_a, 64'h8000_0000);

      // Release reset and feed dout+4 back every cycle.
      rst   = 1'b0;
      wen_b = 1'b0;
      wen_c = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din_a = dout_a + 64'd4;
         edge1();
         check("pc_step", dout_a, 64'h8000_0004 + 64'(4 * i));
      end

      // Writes disabled: the register holds its value.
      wen_a = 1'b0;
      din_a = 64'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         edge1();
         check("hold", dout_a, 64'h8000_000C);
      end

      // A reset pulse that does not span an edge has no effect.
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      check("rst_glitch", dout_a, 64'h8000_000C);
      edge1();
      check("rst_glitch_edge", dout_a, 64'h8000_000C);

      // Reset and write in the same cycle: reset wins.
      rst   = 1'b1;
      wen_a = 1'b1;
      din_a = 64'h5;
      edge1();
      check("rst_priority", dout_a, 64'h8000_0000);

      // After reset is released, the first write lands at the first edge.
      rst = 1'b0;
      edge1();
      check("first_write", dout_a, 64'h5);

      // 1-bit instance: dout is din delayed by exactly one edge.
      wen_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         din_b  = i[0];
         prev_b = din_b;
         edge1();
         check("w1_delay", {63'd0, dout_b}, {63'd0, prev_b});
      end

      // 8-bit instance: a full write, then a write of the same value.
      wen_c = 1'b1;
      din_c = 8'h3C;
      edge1();
      check("w8_write", {56'd0, dout_c}, 64'h3C);
      edge1();
      check("w8_same", {56'd0, dout_c}, 64'h3C);

      // Random phase with occasional reset; the compare process checks it.
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 15) == 0);
         wen_a = $urandom_range(0, 1) == 1;
         wen_b = $urandom_range(0, 1) == 1;
         wen_c = $urandom_range(0, 1) == 1;
         din_a = {$urandom, $urandom};
         din_b = $urandom_range(0, 1) == 1;
         din_c = 8'($urandom);
         edge1();
      end

      rst = 1'b0;
      wen_a = 1'b0; wen_b = 1'b0; wen_c = 1'b0;
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ysyx_220053_dff_reg.md
YSYX_220053_DFF_REG -- requirements
Module: ysyx_220053_dff_reg

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the data width in bits (legal range 1..1024).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, WIDTH bits wide, giving the value loaded on reset.

Ports, in this positional order:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port din, input, WIDTH bits: next-state data.
REQ-006 The block SHALL have port dout, output, WIDTH bits: current register contents.
REQ-007 The block SHALL have port wen, input, 1 bit: write enable, active-high.
REQ-008 The block SHALL keep this positional port order exactly (clk, rst, din, dout, wen), because instantiation sites connect by position.

Function
REQ-009 The block SHALL hold one WIDTH-bit state register and drive dout directly from it, with no combinational path from din, wen or rst to dout.
REQ-010 At a rising clk edge with rst=1, the register SHALL load RESET_VAL, regardless of wen and din.
REQ-011 At a rising clk edge with rst=0 and wen=1, the register SHALL load din.
REQ-012 At a rising clk edge with rst=0 and wen=0, the register SHALL hold its value.
REQ-013 Write latency SHALL be one cycle: din sampled at edge N appears on dout immediately after edge N and stays stable until the next qualifying edge.
REQ-014 When rst=1 and wen=1 in the same cycle, rst SHALL take priority.
REQ-015 A write SHALL update all WIDTH bits; there are no partial or byte writes.
REQ-016 A write with din equal to the current value SHALL leave dout unchanged, with no glitch.
REQ-017 RESET_VAL wider than WIDTH SHALL be truncated to its low WIDTH bits.
REQ-018 RESET_VAL narrower than WIDTH SHALL be zero-extended.
REQ-019 Before the first reset edge, dout SHALL be unspecified (X in simulation); users must apply rst for at least one clock edge.
REQ-020 X or Z on wen while rst=0 SHALL propagate X into the register in simulation and SHALL NOT be masked.

Reset
REQ-021 Reset SHALL be synchronous: asserting rst between clock edges SHALL NOT change dout until the next rising clk edge.
REQ-022 Deasserting rst SHALL let the first write take effect at the first rising edge sampled with rst=0.
REQ-023 Reset asserted mid-operation SHALL discard any concurrent write and load RESET_VAL.
REQ-024 The reset value of dout SHALL be RESET_VAL (for example 64'h80000000 in the PC instance).

Structure
REQ-025 The block SHALL be self-contained, with no shared package, typedefs or sub-modules.
REQ-026 WIDTH and RESET_VAL SHALL be the only configuration.
REQ-027 The block SHALL be a single always block clocked on the rising clk edge.
REQ-028 An elaboration-time check SHALL reject WIDTH < 1.
REQ-029 The block SHALL contain no latches and no additional clocks.
REQ-030 The block SHALL be the generic state element reused for PC, CSRs and pipeline registers.

Verification (WIDTH=64, RESET_VAL=64'h80000000 unless stated)
REQ-031 Scenario: rst=1 for 2 edges, wen=1, din=64'h1234 -> dout=64'h80000000 after the first edge.
REQ-032 Scenario: release rst, wen=1, din = dout+4 fed back every cycle -> dout steps 80000000, 80000004, 80000008, 8000000C on successive edges.
REQ-033 Scenario: wen=0, din=64'hDEADBEEF for 3 edges -> dout holds its previous value.
REQ-034 Scenario: rst pulsed high between edges without spanning an edge -> dout unchanged; rst high at an edge with wen=1, din=64'h5 -> dout=64'h80000000.
REQ-035 Scenario: WIDTH=1, RESET_VAL=1, alternating din with wen=1 -> dout equals din delayed by exactly one cycle.
REQ-036 Scenario: WIDTH=8, RESET_VAL=9'h1AB -> dout=8'hAB after reset.
